// File: rtl/spi_xfer_sequencer_if.sv
// Bundles the push/pop side and the SPI host handshake of spi_xfer_sequencer.
// slave is the sequencer's view; master is the user/host-side view.
interface spi_xfer_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned LevelW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  tx_full;
  logic [LevelW-1:0]     tx_level;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_en;
  logic                  rx_empty;
  logic [LevelW-1:0]     rx_level;
  logic [DATA_WIDTH-1:0] host_tx_data;
  logic                  host_tx_start;
  logic [DATA_WIDTH-1:0] host_rx_data;
  logic                  host_rx_valid;
  logic                  host_tx_done;
  logic                  busy;
  logic                  clr_err;
  logic                  tx_overflow;
  logic                  rx_overflow;
  logic                  timeout_err;

  modport slave (
    input  wr_data, wr_en, rd_en, host_rx_data, host_rx_valid, host_tx_done, clr_err,
    output tx_full, tx_level, rd_data, rx_empty, rx_level, host_tx_data, host_tx_start,
           busy, tx_overflow, rx_overflow, timeout_err
  );

  modport master (
    output wr_data, wr_en, rd_en, host_rx_data, host_rx_valid, host_tx_done, clr_err,
    input  tx_full, tx_level, rd_data, rx_empty, rx_level, host_tx_data, host_tx_start,
           busy, tx_overflow, rx_overflow, timeout_err
  );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// TX/RX FIFO front-end for an SPI host: issues buffered words one at a time via a
// start pulse, captures each response, and abandons transfers that stall too long.
module spi_xfer_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input logic                 clk,
  input logic                 rst,
  spi_xfer_sequencer_if.slave bus
);
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned LevelW = $clog2(DEPTH + 1);
  localparam int unsigned TimerW = $clog2(TIMEOUT);
  localparam logic [LevelW-1:0] DepthL    = LevelW'(DEPTH);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] tx_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem_q [DEPTH];
  logic [PtrW-1:0]       tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
  logic [LevelW-1:0]     tx_level_q, rx_level_q;
  logic [TimerW-1:0]     timer_q;
  logic [DATA_WIDTH-1:0] host_tx_data_q;
  logic                  host_tx_start_q;
  logic                  tx_ovf_q, rx_ovf_q, tmo_q;

  logic tx_full, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop, rx_valid_wait;
  logic unused_host_tx_done;

  assign unused_host_tx_done = bus.host_tx_done;

  always_comb begin
    tx_full       = (tx_level_q == DepthL);
    rx_full       = (rx_level_q == DepthL);
    rx_empty      = (rx_level_q == '0);
    tx_push       = bus.wr_en && !tx_full;
    // Only issue when the response is guaranteed a slot in the RX FIFO.
    tx_pop        = (state_q == StIdle) && (tx_level_q != '0) && !rx_full;
    rx_valid_wait = (state_q == StWait) && bus.host_rx_valid;
    rx_push       = rx_valid_wait && !rx_full;
    rx_pop        = bus.rd_en && !rx_empty;
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= bus.wr_data;
    if (rx_push) rx_mem_q[rx_wptr_q] <= bus.host_rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      tx_level_q <= '0;
      rx_level_q <= '0;
      tx_ovf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + PtrW'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + PtrW'(1);
      if (rx_push) rx_wptr_q <= rx_wptr_q + PtrW'(1);
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + PtrW'(1);

      if (tx_push && !tx_pop)      tx_level_q <= tx_level_q + LevelW'(1);
      else if (!tx_push && tx_pop) tx_level_q <= tx_level_q - LevelW'(1);
      if (rx_push && !rx_pop)      rx_level_q <= rx_level_q + LevelW'(1);
      else if (!rx_push && rx_pop) rx_level_q <= rx_level_q - LevelW'(1);

      tx_ovf_q <= (tx_ovf_q && !bus.clr_err) || (bus.wr_en && tx_full);
      rx_ovf_q <= (rx_ovf_q && !bus.clr_err) || (rx_valid_wait && rx_full);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      timer_q         <= '0;
      host_tx_data_q  <= '0;
      host_tx_start_q <= 1'b0;
      tmo_q           <= 1'b0;
    end else begin
      tmo_q <= tmo_q && !bus.clr_err;
      case (state_q)
        StIdle: begin
          if (tx_pop) begin
            host_tx_data_q  <= tx_mem_q[tx_rptr_q];
            host_tx_start_q <= 1'b1;
            state_q         <= StIssue;
          end
        end
        StIssue: begin
          host_tx_start_q <= 1'b0;
          timer_q         <= '0;
          state_q         <= StWait;
        end
        StWait: begin
          if (bus.host_rx_valid) begin
            state_q <= StIdle;
          end else if (timer_q == TimerLast) begin
            tmo_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.tx_full       = tx_full;
  assign bus.tx_level      = tx_level_q;
  assign bus.rx_empty      = rx_empty;
  assign bus.rx_level      = rx_level_q;
  assign bus.rd_data       = rx_empty ? '0 : rx_mem_q[rx_rptr_q];
  assign bus.host_tx_data  = host_tx_data_q;
  assign bus.host_tx_start = host_tx_start_q;
  assign bus.busy          = (state_q != StIdle);
  assign bus.tx_overflow   = tx_ovf_q;
  assign bus.rx_overflow   = rx_ovf_q;
  assign bus.timeout_err   = tmo_q;
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer: a per-cycle vector table plus hand-written
// sequences for overflow, backpressure, timeout and reset corner cases.
module tb_spi_xfer_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_xfer_sequencer_if #(.DATA_WIDTH(8), .DEPTH(4)) bus ();
  spi_xfer_sequencer_if #(.DATA_WIDTH(8), .DEPTH(4)) tbus ();

  spi_xfer_sequencer #(.DATA_WIDTH(8), .DEPTH(4), .TIMEOUT(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  spi_xfer_sequencer #(.DATA_WIDTH(8), .DEPTH(4), .TIMEOUT(16)) dut_tmo (
    .clk (clk),
    .rst (rst),
    .bus (tbus)
  );

  int checks = 0;
  int failures = 0;
  int served = 0;
  int pulses;
  logic [7:0] issued [64];

  // Start-pulse monitor on the main instance.
  always @(negedge clk) begin
    if (rst) begin
      pulses <= 0;
    end else if (bus.host_tx_start && pulses < 64) begin
      issued[pulses] <= bus.host_tx_data;
      pulses         <= pulses + 1;
    end
  end

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       rxv;
    logic [7:0] rxd;
    logic [2:0] tx_lvl;
    logic [2:0] rx_lvl;
    logic       start;
    logic [7:0] txd;
    logic       busy;
    logic [7:0] rdd;
    logic       empty;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en = 0;  bus.wr_data = 0;  bus.rd_en = 0;  bus.clr_err = 0;
    bus.host_rx_valid = 0;  bus.host_rx_data = 0;  bus.host_tx_done = 0;
    tbus.wr_en = 0; tbus.wr_data = 0; tbus.rd_en = 0; tbus.clr_err = 0;
    tbus.host_rx_valid = 0; tbus.host_rx_data = 0; tbus.host_tx_done = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
    served = 0;
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_en = 1;
    bus.wr_data = d;
    step();
    bus.wr_en = 0;
  endtask

  // Waits for an outstanding transfer to reach WAIT, then returns resp for it.
  task automatic serve(input logic [7:0] resp);
    int n;
    n = 0;
    while ((pulses <= served || bus.host_tx_start) && n < 100) begin
      step();
      n++;
    end
    check("serve_wait", 32'(n < 100), 1);
    bus.host_rx_valid = 1;
    bus.host_rx_data  = resp;
    step();
    bus.host_rx_valid = 0;
    served++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    //          wr  wd     rd  rxv rxd    txl rxl st  txd    bsy rdd    emp
    vecs[0]  = '{1, 8'hA5, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 1};
    vecs[1]  = '{1, 8'h11, 0, 0, 8'h00, 1, 0, 1, 8'hA5, 1, 8'h00, 1};
    vecs[2]  = '{1, 8'h22, 0, 0, 8'h00, 2, 0, 0, 8'hA5, 1, 8'h00, 1};
    vecs[3]  = '{0, 8'h00, 0, 1, 8'h3C, 2, 1, 0, 8'hA5, 0, 8'h3C, 0};
    vecs[4]  = '{0, 8'h00, 0, 0, 8'h00, 1, 1, 1, 8'h11, 1, 8'h3C, 0};
    vecs[5]  = '{0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 8'h11, 1, 8'h3C, 0};
    vecs[6]  = '{0, 8'h00, 0, 1, 8'h4D, 1, 2, 0, 8'h11, 0, 8'h3C, 0};
    vecs[7]  = '{0, 8'h00, 0, 0, 8'h00, 0, 2, 1, 8'h22, 1, 8'h3C, 0};
    vecs[8]  = '{0, 8'h00, 0, 0, 8'h00, 0, 2, 0, 8'h22, 1, 8'h3C, 0};
    vecs[9]  = '{0, 8'h00, 1, 1, 8'h5E, 0, 2, 0, 8'h22, 0, 8'h4D, 0};
    vecs[10] = '{0, 8'h00, 1, 0, 8'h00, 0, 1, 0, 8'h22, 0, 8'h5E, 0};
    vecs[11] = '{0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h22, 0, 8'h00, 1};
    vecs[12] = '{0, 8'h00, 1, 1, 8'h77, 0, 0, 0, 8'h22, 0, 8'h00, 1};

    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;

    // Reset state
    check("rst_tx_level", bus.tx_level, 0);
    check("rst_rx_level", bus.rx_level, 0);
    check("rst_tx_full", bus.tx_full, 0);
    check("rst_rx_empty", bus.rx_empty, 1);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_start", bus.host_tx_start, 0);
    check("rst_tx_data", bus.host_tx_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_flags", {bus.tx_overflow, bus.rx_overflow, bus.timeout_err}, 0);
    check("rst_tmo_flag", tbus.timeout_err, 0);

    // Cycle-by-cycle table: issue, back-to-back, simultaneous push/pop, empty pop
    for (int i = 0; i < 13; i++) begin
      bus.wr_en = vecs[i].wr;
      bus.wr_data = vecs[i].wd;
      bus.rd_en = vecs[i].rd;
      bus.host_rx_valid = vecs[i].rxv;
      bus.host_rx_data = vecs[i].rxd;
      step();
      check($sformatf("v%0d_tx_level", i), bus.tx_level, vecs[i].tx_lvl);
      check($sformatf("v%0d_rx_level", i), bus.rx_level, vecs[i].rx_lvl);
      check($sformatf("v%0d_start", i), bus.host_tx_start, vecs[i].start);
      check($sformatf("v%0d_tx_data", i), bus.host_tx_data, vecs[i].txd);
      check($sformatf("v%0d_busy", i), bus.busy, vecs[i].busy);
      check($sformatf("v%0d_rd_data", i), bus.rd_data, vecs[i].rdd);
      check($sformatf("v%0d_rx_empty", i), bus.rx_empty, vecs[i].empty);
    end
    idle_inputs();
    check("tbl_flags", {bus.tx_overflow, bus.rx_overflow, bus.timeout_err}, 0);

    // Single word, 40-cycle host latency
    do_reset();
    push(8'hA5);
    n = 0;
    while (pulses == 0 && n < 20) begin
      step();
      n++;
    end
    check("single_pulse_seen", 32'(n < 20), 1);
    check("single_tx_data", issued[0], 8'hA5);
    repeat (39) step();
    bus.host_rx_valid = 1;
    bus.host_rx_data = 8'h3C;
    step();
    bus.host_rx_valid = 0;
    check("single_rd_data", bus.rd_data, 8'h3C);
    check("single_rx_empty", bus.rx_empty, 0);
    repeat (5) step();
    check("single_pulse_count", pulses, 1);
    check("single_tmo", bus.timeout_err, 0);

    // Full TX FIFO while the host is stalled on an earlier word
    do_reset();
    push(8'h90);
    step();
    for (int i = 1; i <= 5; i++) push(8'hB0 + 8'(i));
    check("full_tx_full", bus.tx_full, 1);
    check("full_tx_level", bus.tx_level, 4);
    check("full_tx_ovf", bus.tx_overflow, 1);
    bus.clr_err = 1;
    step();
    bus.clr_err = 0;
    check("full_clr_ovf", bus.tx_overflow, 0);
    serve(8'h01);
    push(8'hB6);  // lands in the same cycle as the FSM pop; still full beforehand
    check("full_pop_write_ovf", bus.tx_overflow, 1);
    check("full_pop_write_level", bus.tx_level, 3);
    for (int i = 1; i <= 4; i++) begin
      serve(8'h10 + 8'(i));
      bus.rd_en = 1;
      step();
      bus.rd_en = 0;
    end
    repeat (30) step();
    check("full_pulse_count", pulses, 5);
    check("full_first_word", issued[0], 8'h90);
    for (int i = 1; i <= 4; i++) check($sformatf("full_word%0d", i), issued[i], 8'hB0 + 8'(i));
    check("full_drained", bus.tx_level, 0);

    // RX backpressure: FSM parks once the RX FIFO holds DEPTH responses
    do_reset();
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
    serve(8'h50);
    step();
    push(8'hC5);
    check("bp_no_tx_ovf", bus.tx_overflow, 0);
    for (int i = 1; i <= 3; i++) serve(8'h50 + 8'(i));
    repeat (10) step();
    check("bp_pulses", pulses, 4);
    check("bp_tx_level", bus.tx_level, 2);
    check("bp_rx_level", bus.rx_level, 4);
    check("bp_busy", bus.busy, 0);
    check("bp_rx_ovf", bus.rx_overflow, 0);
    for (int i = 0; i < 4; i++) check($sformatf("bp_word%0d", i), issued[i], 8'hC0 + 8'(i));
    bus.rd_en = 1;
    step();
    bus.rd_en = 0;
    check("bp_pop_head", bus.rd_data, 8'h51);
    step();
    check("bp_resume_start", bus.host_tx_start, 1);
    check("bp_resume_data", bus.host_tx_data, 8'hC4);
    step();
    check("bp_pulses_after_pop", pulses, 5);

    // Timeout with TIMEOUT=16
    do_reset();
    tbus.wr_en = 1;
    tbus.wr_data = 8'hD1;
    step();
    tbus.wr_en = 0;
    step();
    check("tmo_start", tbus.host_tx_start, 1);
    repeat (16) step();
    check("tmo_not_yet", tbus.timeout_err, 0);
    check("tmo_still_busy", tbus.busy, 1);
    step();
    check("tmo_set", tbus.timeout_err, 1);
    check("tmo_idle", tbus.busy, 0);
    tbus.host_rx_valid = 1;
    tbus.host_rx_data = 8'h99;
    step();
    tbus.host_rx_valid = 0;
    check("tmo_late_level", tbus.rx_level, 0);
    check("tmo_late_empty", tbus.rx_empty, 1);
    tbus.clr_err = 1;
    step();
    tbus.clr_err = 0;
    check("tmo_cleared", tbus.timeout_err, 0);

    // Reset in WAIT
    do_reset();
    for (int i = 0; i < 6; i++) push(8'hE0 + 8'(i));
    check("rw_pre_ovf", bus.tx_overflow, 1);
    check("rw_pre_busy", bus.busy, 1);
    rst = 1;
    step();
    rst = 0;
    check("rw_tx_level", bus.tx_level, 0);
    check("rw_rx_level", bus.rx_level, 0);
    check("rw_busy", bus.busy, 0);
    check("rw_start", bus.host_tx_start, 0);
    check("rw_tx_data", bus.host_tx_data, 0);
    check("rw_flags", {bus.tx_overflow, bus.rx_overflow, bus.timeout_err}, 0);
    check("rw_tx_full", bus.tx_full, 0);
    bus.host_rx_valid = 1;
    bus.host_rx_data = 8'hAB;
    step();
    bus.host_rx_valid = 0;
    check("rw_late_level", bus.rx_level, 0);
    check("rw_late_rd_data", bus.rd_data, 0);
    repeat (3) step();
    check("rw_stays_idle", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
